// File: rtl/sonar_axis_recorder_if.sv
// Stream bundle for sonar_axis_recorder: snooped AXI-Stream tap (mon_*)
// plus the 64-bit record stream it emits (rec_*).
// Ports (slave = recorder side):
//   mon_tdata/tkeep/tlast/tvalid/tready  in   snooped stream, never driven
//   rec_tdata/tvalid/tlast               out  record words
//   rec_tready                           in   downstream ready
interface sonar_axis_recorder_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0]   mon_tdata;
   logic [DATA_WIDTH/8-1:0] mon_tkeep;
   logic                    mon_tlast;
   logic                    mon_tvalid;
   logic                    mon_tready;
   logic [63:0]             rec_tdata;
   logic                    rec_tvalid;
   logic                    rec_tready;
   logic                    rec_tlast;

   modport slave (
      input  mon_tdata,
      input  mon_tkeep,
      input  mon_tlast,
      input  mon_tvalid,
      input  mon_tready,
      output rec_tdata,
      output rec_tvalid,
      output rec_tlast,
      input  rec_tready
   );

   modport master (
      output mon_tdata,
      output mon_tkeep,
      output mon_tlast,
      output mon_tvalid,
      output mon_tready,
      input  rec_tdata,
      input  rec_tvalid,
      input  rec_tlast,
      output rec_tready
   );
endinterface

// File: rtl/sonar_axis_recorder.sv
// Passive AXI-Stream recorder: each snooped handshake becomes a 4-word
// record (HDR, TS, DATA, SIDE) on a 64-bit stream, buffered by a FIFO.
// Ports:
//   ap_clk, ap_rst_n     clock, async active-low reset
//   enable               capture enable, sampled every cycle
//   bus (slave)          mon_* tap inputs, rec_* record stream
//   overflow             sticky, set when a beat is dropped
//   clear_overflow       sync clear of overflow and drop_count
//   drop_count           dropped beats, saturating
module sonar_axis_recorder #(
   parameter int         DATA_WIDTH = 64,
   parameter int         FIFO_DEPTH = 16,
   parameter int         TS_WIDTH   = 32,
   parameter logic [7:0] TYPE_CODE  = 8'h01
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  enable,
   sonar_axis_recorder_if.slave  bus,
   output logic                  overflow,
   input  logic                  clear_overflow,
   output logic [15:0]           drop_count
);
   localparam int KeepW  = DATA_WIDTH / 8;
   localparam int AddrW  = $clog2(FIFO_DEPTH);
   localparam int EntryW = TS_WIDTH + DATA_WIDTH + KeepW + 1;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      TS,
      DATA,
      SIDE
   } state_t;

   state_t state;

   logic [TS_WIDTH-1:0]   tsCount;
   logic [15:0]           seqNum;
   logic [EntryW-1:0]     mem [FIFO_DEPTH];
   logic [AddrW-1:0]      wrPtr;
   logic [AddrW-1:0]      rdPtr;
   logic [AddrW:0]        fill;
   logic [AddrW:0]        fillNext;

   logic [EntryW-1:0]     head;
   logic [TS_WIDTH-1:0]   headTs;
   logic [DATA_WIDTH-1:0] headData;
   logic [KeepW-1:0]      headKeep;
   logic                  headLast;

   logic beatSeen;
   logic fifoFull;
   logic fifoEmpty;
   logic pop;
   logic push;
   logic drop;

   assign beatSeen  = enable & bus.mon_tvalid & bus.mon_tready;
   assign fifoFull  = (fill == (AddrW+1)'(FIFO_DEPTH));
   assign fifoEmpty = (fill == '0);

   // The head entry leaves only when its SIDE word is accepted.
   assign pop  = (state == SIDE) & bus.rec_tvalid & bus.rec_tready;
   // A full FIFO still takes a beat when the head leaves that cycle.
   assign push = beatSeen & (~fifoFull | pop);
   assign drop = beatSeen & ~push;

   assign head = mem[rdPtr];
   assign {headTs, headData, headKeep, headLast} = head;

   always_comb begin
      fillNext = fill;
      unique case ({push, pop})
         2'b10:   fillNext = fill + (AddrW+1)'(1);
         2'b01:   fillNext = fill - (AddrW+1)'(1);
         default: fillNext = fill;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem[wrPtr] <= {tsCount, bus.mon_tdata,
                        bus.mon_tkeep, bus.mon_tlast};
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         tsCount <= '0;
         wrPtr   <= '0;
         rdPtr   <= '0;
         fill    <= '0;
      end else begin
         tsCount <= tsCount + TS_WIDTH'(1);
         fill    <= fillNext;
         if (push) begin
            wrPtr <= wrPtr + AddrW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + AddrW'(1);
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_overflow) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   // Words are loaded one state ahead so rec_* are plain registers
   // that hold still while the sink stalls.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state          <= IDLE;
         seqNum         <= '0;
         bus.rec_tvalid <= 1'b0;
         bus.rec_tdata  <= '0;
         bus.rec_tlast  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!fifoEmpty) begin
                  state          <= HDR;
                  bus.rec_tvalid <= 1'b1;
                  bus.rec_tdata  <= {TYPE_CODE, 8'd3,
                                     seqNum, 32'd0};
               end
            end
            HDR: begin
               if (bus.rec_tready) begin
                  state         <= TS;
                  bus.rec_tdata <= 64'(headTs);
               end
            end
            TS: begin
               if (bus.rec_tready) begin
                  state         <= DATA;
                  bus.rec_tdata <= 64'(headData);
               end
            end
            DATA: begin
               if (bus.rec_tready) begin
                  state         <= SIDE;
                  bus.rec_tdata <= {headLast, 63'(headKeep)};
                  bus.rec_tlast <= 1'b1;
               end
            end
            SIDE: begin
               if (bus.rec_tready) begin
                  seqNum        <= seqNum + 16'd1;
                  bus.rec_tlast <= 1'b0;
                  if (fillNext != '0) begin
                     state         <= HDR;
                     bus.rec_tdata <= {TYPE_CODE, 8'd3,
                                       seqNum + 16'd1, 32'd0};
                  end else begin
                     state          <= IDLE;
                     bus.rec_tvalid <= 1'b0;
                     bus.rec_tdata  <= '0;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               bus.rec_tvalid <= 1'b0;
               bus.rec_tdata  <= '0;
               bus.rec_tlast  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sonar_axis_recorder.sv
// Directed bench for sonar_axis_recorder: single beat, backpressure,
// overflow, full-with-pop, filtering and reset in mid-record.
module tb_sonar_axis_recorder;
   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        enable;
   logic        clear_overflow;
   logic        overflow;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] words [$];
   logic        lasts [$];

   sonar_axis_recorder_if #(.DATA_WIDTH(64)) ifc ();

   sonar_axis_recorder #(
      .DATA_WIDTH(64),
      .FIFO_DEPTH(16),
      .TS_WIDTH  (32),
      .TYPE_CODE (8'h01)
   ) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .enable        (enable),
      .bus           (ifc),
      .overflow      (overflow),
      .clear_overflow(clear_overflow),
      .drop_count    (drop_count)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic idleMon();
      ifc.mon_tdata  = '0;
      ifc.mon_tkeep  = '0;
      ifc.mon_tlast  = 1'b0;
      ifc.mon_tvalid = 1'b0;
      ifc.mon_tready = 1'b0;
   endtask

   task automatic doReset();
      ap_rst_n       = 1'b0;
      enable         = 1'b1;
      clear_overflow = 1'b0;
      ifc.rec_tready = 1'b0;
      idleMon();
      repeat (3) tick();
      ap_rst_n = 1'b1;
   endtask

   task automatic beat(input logic [63:0] d,
                       input logic [7:0] k,
                       input logic l);
      ifc.mon_tdata  = d;
      ifc.mon_tkeep  = k;
      ifc.mon_tlast  = l;
      ifc.mon_tvalid = 1'b1;
      ifc.mon_tready = 1'b1;
      tick();
      idleMon();
   endtask

   task automatic collect(input int n, input int budget);
      words.delete();
      lasts.delete();
      ifc.rec_tready = 1'b1;
      for (int i = 0; i < budget && words.size() < n; i++) begin
         if (ifc.rec_tvalid) begin
            words.push_back(ifc.rec_tdata);
            lasts.push_back(ifc.rec_tlast);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      ap_rst_n       = 1'b0;
      enable         = 1'b0;
      clear_overflow = 1'b0;
      ifc.rec_tready = 1'b0;
      idleMon();
      tick();
      tick();
      checks++;
      if ({ifc.rec_tvalid, ifc.rec_tlast} !== 2'b00) begin
         errors++;
         $display("FAIL rst_valid_last got %b want 00",
                  {ifc.rec_tvalid, ifc.rec_tlast});
      end
      checks++;
      if (ifc.rec_tdata !== 64'd0) begin
         errors++;
         $display("FAIL rst_tdata got %h want 0", ifc.rec_tdata);
      end
      checks++;
      if ({overflow, drop_count} !== 17'd0) begin
         errors++;
         $display("FAIL rst_ovf got %b/%0d want 0/0",
                  overflow, drop_count);
      end
      ap_rst_n = 1'b1;
   endtask

   task automatic test_single_beat();
      logic [65:0] exp [4];
      exp[0] = {1'b1, 1'b0, 64'h0103_0000_0000_0000};
      exp[1] = {1'b1, 1'b0, 64'd10};
      exp[2] = {1'b1, 1'b0, 64'hDEADBEEF_01234567};
      exp[3] = {1'b1, 1'b1, 64'h8000_0000_0000_00FF};
      doReset();
      ifc.rec_tready = 1'b1;
      repeat (10) tick();
      beat(64'hDEADBEEF_01234567, 8'hFF, 1'b1);
      checks++;
      if (ifc.rec_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL sb_early_valid got %b want 0",
                  ifc.rec_tvalid);
      end
      for (int w = 0; w < 4; w++) begin
         tick();
         checks++;
         if ({ifc.rec_tvalid, ifc.rec_tlast, ifc.rec_tdata}
             !== exp[w]) begin
            errors++;
            $display("FAIL sb_word%0d got %h want %h", w,
                     {ifc.rec_tvalid, ifc.rec_tlast,
                      ifc.rec_tdata}, exp[w]);
         end
      end
      tick();
      checks++;
      if (ifc.rec_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL sb_end_valid got %b want 0",
                  ifc.rec_tvalid);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp [8];
      logic [63:0] got [8];
      logic [63:0] prevWord;
      logic        prevStall;
      int          n;
      exp[0] = 64'h0103_0000_0000_0000;
      exp[1] = 64'd3;
      exp[2] = 64'h1111_2222_3333_4444;
      exp[3] = 64'h0000_0000_0000_000F;
      exp[4] = 64'h0103_0001_0000_0000;
      exp[5] = 64'd4;
      exp[6] = 64'hA5A5_5A5A_0F0F_F0F0;
      exp[7] = 64'h8000_0000_0000_00FF;
      doReset();
      repeat (3) tick();
      beat(64'h1111_2222_3333_4444, 8'h0F, 1'b0);
      beat(64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1'b1);
      n         = 0;
      prevStall = 1'b0;
      prevWord  = '0;
      for (int i = 0; i < 100 && n < 8; i++) begin
         ifc.rec_tready = (i % 3 == 0);
         if (prevStall) begin
            checks++;
            if ({ifc.rec_tvalid, ifc.rec_tdata}
                !== {1'b1, prevWord}) begin
               errors++;
               $display("FAIL bp_hold got %b/%h want 1/%h",
                        ifc.rec_tvalid, ifc.rec_tdata,
                        prevWord);
            end
         end
         if (ifc.rec_tvalid && ifc.rec_tready) begin
            got[n] = ifc.rec_tdata;
            n++;
         end
         prevStall = ifc.rec_tvalid & ~ifc.rec_tready;
         prevWord  = ifc.rec_tdata;
         tick();
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL bp_count got %0d want 8", n);
      end
      for (int w = 0; w < 8; w++) begin
         checks++;
         if (got[w] !== exp[w]) begin
            errors++;
            $display("FAIL bp_word%0d got %h want %h",
                     w, got[w], exp[w]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [63:0] eh;
      doReset();
      repeat (2) tick();
      for (int i = 0; i < 20; i++) begin
         beat(64'h100 + 64'(i), 8'hFF, 1'b0);
      end
      checks++;
      if ({overflow, drop_count} !== {1'b1, 16'd4}) begin
         errors++;
         $display("FAIL ovf_count got %b/%0d want 1/4",
                  overflow, drop_count);
      end
      collect(64, 400);
      checks++;
      if (words.size() != 64) begin
         errors++;
         $display("FAIL ovf_words got %0d want 64",
                  words.size());
      end
      for (int r = 0; r < 16; r++) begin
         eh = {8'h01, 8'h03, 16'(r), 32'd0};
         checks++;
         if (words[4*r] !== eh) begin
            errors++;
            $display("FAIL ovf_hdr%0d got %h want %h",
                     r, words[4*r], eh);
         end
         checks++;
         if (words[4*r+1] !== 64'(2 + r)) begin
            errors++;
            $display("FAIL ovf_ts%0d got %0d want %0d",
                     r, words[4*r+1], 2 + r);
         end
         checks++;
         if (words[4*r+2] !== 64'h100 + 64'(r)) begin
            errors++;
            $display("FAIL ovf_data%0d got %h want %h",
                     r, words[4*r+2], 64'h100 + 64'(r));
         end
      end
      checks++;
      if (ifc.rec_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_extra got %b want 0",
                  ifc.rec_tvalid);
      end
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      checks++;
      if ({overflow, drop_count} !== 17'd0) begin
         errors++;
         $display("FAIL ovf_clear got %b/%0d want 0/0",
                  overflow, drop_count);
      end
   endtask

   task automatic test_full_pop();
      doReset();
      for (int i = 0; i < 16; i++) begin
         beat(64'h200 + 64'(i), 8'hFF, 1'b0);
      end
      clear_overflow = 1'b1;
      beat(64'h0BAD, 8'hFF, 1'b0);
      clear_overflow = 1'b0;
      checks++;
      if ({overflow, drop_count} !== 17'd0) begin
         errors++;
         $display("FAIL fp_clrwins got %b/%0d want 0/0",
                  overflow, drop_count);
      end
      beat(64'h0BAD, 8'hFF, 1'b0);
      checks++;
      if ({overflow, drop_count} !== {1'b1, 16'd1}) begin
         errors++;
         $display("FAIL fp_drop got %b/%0d want 1/1",
                  overflow, drop_count);
      end
      ifc.rec_tready = 1'b1;
      repeat (3) tick();
      checks++;
      if ({ifc.rec_tvalid, ifc.rec_tlast} !== 2'b11) begin
         errors++;
         $display("FAIL fp_side got %b want 11",
                  {ifc.rec_tvalid, ifc.rec_tlast});
      end
      beat(64'hC0FFEE, 8'hFF, 1'b1);
      checks++;
      if (drop_count !== 16'd1) begin
         errors++;
         $display("FAIL fp_accept got %0d want 1", drop_count);
      end
      collect(64, 400);
      checks++;
      if (words.size() != 64) begin
         errors++;
         $display("FAIL fp_words got %0d want 64",
                  words.size());
      end
      checks++;
      if (words[0] !== 64'h0103_0001_0000_0000) begin
         errors++;
         $display("FAIL fp_hdr1 got %h want 0103000100000000",
                  words[0]);
      end
      checks++;
      if (words[60] !== 64'h0103_0010_0000_0000) begin
         errors++;
         $display("FAIL fp_hdr16 got %h want 0103001000000000",
                  words[60]);
      end
      checks++;
      if ({words[62], words[63]} !==
          {64'hC0FFEE, 64'h8000_0000_0000_00FF}) begin
         errors++;
         $display("FAIL fp_marker got %h %h want C0FFEE/80..FF",
                  words[62], words[63]);
      end
   endtask

   task automatic test_filtering();
      logic saw;
      doReset();
      ifc.rec_tready = 1'b1;
      ifc.mon_tvalid = 1'b1;
      ifc.mon_tdata  = 64'h77;
      repeat (3) tick();
      idleMon();
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (ifc.rec_tvalid) saw = 1'b1;
         tick();
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL flt_noready got %b want 0", saw);
      end
      enable = 1'b0;
      beat(64'h88, 8'hFF, 1'b1);
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (ifc.rec_tvalid) saw = 1'b1;
         tick();
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL flt_disabled got %b want 0", saw);
      end
      enable = 1'b1;
      beat(64'h1234_5678_9ABC_DEF0, 8'h3C, 1'b1);
      enable = 1'b0;
      collect(4, 20);
      checks++;
      if (words.size() != 4) begin
         errors++;
         $display("FAIL flt_midwords got %0d want 4",
                  words.size());
      end
      checks++;
      if ({words[0], words[2], words[3]} !==
          {64'h0103_0000_0000_0000, 64'h1234_5678_9ABC_DEF0,
           64'h8000_0000_0000_003C}) begin
         errors++;
         $display("FAIL flt_midrec got %h %h %h want hdr0/data/side",
                  words[0], words[2], words[3]);
      end
      checks++;
      if ({lasts[2], lasts[3]} !== 2'b01) begin
         errors++;
         $display("FAIL flt_tlast got %b want 01",
                  {lasts[2], lasts[3]});
      end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic saw;
      doReset();
      ifc.rec_tready = 1'b1;
      beat(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0);
      beat(64'hBBBB_0000_0000_0002, 8'hFF, 1'b0);
      tick();
      tick();
      checks++;
      if ({ifc.rec_tvalid, ifc.rec_tdata} !==
          {1'b1, 64'hAAAA_0000_0000_0001}) begin
         errors++;
         $display("FAIL rm_data got %b/%h want 1/AAAA..01",
                  ifc.rec_tvalid, ifc.rec_tdata);
      end
      #2;
      ap_rst_n = 1'b0;
      #1;
      checks++;
      if (ifc.rec_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL rm_async got %b want 0", ifc.rec_tvalid);
      end
      tick();
      ap_rst_n = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (ifc.rec_tvalid) saw = 1'b1;
         tick();
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL rm_empty got %b want 0", saw);
      end
      beat(64'hCCCC_0000_0000_0003, 8'hFF, 1'b0);
      collect(4, 20);
      checks++;
      if ({words[0], words[2]} !==
          {64'h0103_0000_0000_0000, 64'hCCCC_0000_0000_0003}) begin
         errors++;
         $display("FAIL rm_seq0 got %h %h want hdr0/CCCC..03",
                  words[0], words[2]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_beat();
      test_backpressure();
      test_overflow();
      test_full_pop();
      test_filtering();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sonar_axis_recorder.md
Name: sonar_axis_recorder

Overview:
- Synthesizable capture block that sits on a DUT AXI-Stream port and observes it without driving it.
- Converts each observed handshake into a fixed-format 4-word record, so captured activity can be read back, logged or compared against vector-file packets.
- It is the write side of the packet format the exerciser consumes: packet type, argument count, then arguments.
- Instantiated in the bench or on-chip next to the DUT, with one recorder per monitored stream.

Parameters:
- DATA_WIDTH, 64, monitored tdata width; legal values are 8..64 in multiples of 8.
- FIFO_DEPTH, 16, capture FIFO entries; must be a power of 2, at least 2.
- TS_WIDTH, 32, timestamp counter width; legal values are 1..64.
- TYPE_CODE, 8'h01, packet type code written into every header.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable; sampled every cycle
- mon_tdata  in  DATA_WIDTH  snooped data
- mon_tkeep  in  DATA_WIDTH/8  snooped keep
- mon_tlast  in  1  snooped last
- mon_tvalid  in  1  snooped valid
- mon_tready  in  1  snooped ready (input only; never driven)
- rec_tdata  out  64  record word
- rec_tvalid  out  1  record word valid
- rec_tready  in  1  downstream ready
- rec_tlast  out  1  high on word 3 of each record
- overflow  out  1  sticky; a beat was dropped
- clear_overflow  in  1  synchronous clear of overflow and drop_count
- drop_count  out  16  beats dropped; saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, FIFO empty, FSM in IDLE.
  - Timestamp counter = 0, sequence number = 0.
- Timestamp:
  - Free-running TS_WIDTH counter, +1 every cycle, wraps to 0.
  - The value captured is the counter value in the cycle of the handshake.
- Capture:
  - Condition: enable & mon_tvalid & mon_tready at a rising edge.
  - Push {ts, tdata, tkeep, tlast}.
  - No capture when enable=0; an in-flight record still drains.
- Full FIFO:
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the beat is dropped: overflow <= 1, drop_count +1 (saturating).
- clear_overflow in the same cycle as a drop: clear wins; the drop is not counted.
- Serializer FSM: IDLE -> HDR -> TS -> DATA -> SIDE -> IDLE.
  - IDLE -> HDR when the FIFO is non-empty.
  - Each of HDR/TS/DATA/SIDE advances only on rec_tvalid & rec_tready.
  - SIDE -> HDR directly if the FIFO is still non-empty after the pop; no bubble.
  - The FIFO head is popped on SIDE acceptance.
- Words (all unused bits zero):
  - HDR: [63:56]=TYPE_CODE, [55:48]=8'd3 (arg count), [47:32]=sequence number.
  - TS: [TS_WIDTH-1:0] = timestamp.
  - DATA: [DATA_WIDTH-1:0] = tdata.
  - SIDE: [DATA_WIDTH/8-1:0] = tkeep, [63] = tlast.
- rec_tvalid is high in HDR/TS/DATA/SIDE and low in IDLE.
- Output stability: rec_tdata and rec_tlast are held stable while rec_tvalid & !rec_tready; rec_tvalid never drops before acceptance.
- Sequence number: 16-bit, +1 on each SIDE acceptance, wraps FFFF -> 0.
- Latency:
  - Capture at edge N: FIFO non-empty after N.
  - Header rec_tvalid high after edge N+1 (2-cycle minimum with FIFO empty and FSM idle).
- Throughput: 1 beat per 4 cycles sustained with rec_tready=1; bursts are absorbed by the FIFO.
- Reset mid-record: the record is abandoned with no partial completion; rec_tvalid is 0 immediately on reset assertion.

Test Plan:
- Single beat, no backpressure:
  - Stimulus: reset, enable=1, one handshake at cycle 10 with tdata=64'hDEADBEEF_01234567, tkeep=8'hFF, tlast=1, rec_tready=1.
  - Required: 4 words on consecutive cycles, header first valid 2 cycles after capture.
  - Header = 64'h0103_0000_0000_0000; TS = 10; DATA = input; SIDE = 64'h8000_0000_0000_00FF; rec_tlast only on SIDE.
- Backpressure:
  - Stimulus: as above, but rec_tready toggles 1,0,0,1,...
  - Required: each word held stable while stalled; same 4 words out; sequence number 0 then 1 for a second beat.
- Overflow:
  - Stimulus: FIFO_DEPTH=16, rec_tready=0, 20 consecutive handshakes.
  - Required: 16 stored, drop_count=4, overflow=1.
  - Then rec_tready=1: exactly 16 records with sequence 0..15 and timestamps strictly consecutive.
  - Then clear_overflow pulse: overflow=0, drop_count=0.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, FSM in SIDE with rec_tready=1, handshake in the same cycle.
  - Required: beat accepted, drop_count unchanged.
- Filtering:
  - Stimulus 1: mon_tvalid=1 with mon_tready=0 → no record.
  - Stimulus 2: enable=0 with a handshake → no record.
  - Stimulus 3: enable falls mid-record → that record completes fully.
- Reset mid-record:
  - Stimulus: ap_rst_n low while in DATA state, then release.
  - Required: rec_tvalid=0 asynchronously; after release, FIFO empty and next header sequence = 0.
